// File: rtl/trace_scheduler_pkg.sv
// Shared definitions for the trace scheduler: FSM encoding, frame geometry,
// column-buffer word layout and the height clamp helper.
package trace_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRACING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int H_TOTAL      = 800;
  localparam int V_TOTAL      = 525;
  localparam int VBLANK_START = 480;
  localparam int MAX_HEIGHT   = 240;

  // Column buffer word: side in bit 8, height in bits 7:0.
  typedef struct packed {
    logic       side;
    logic [7:0] height;
  } buf_word_t;

  function automatic logic [7:0] clamp_height(input logic [7:0] h);
    if (h == 8'd0) return 8'd1;
    else if (h > 8'(MAX_HEIGHT)) return 8'(MAX_HEIGHT);
    else return h;
  endfunction

endpackage

// File: rtl/trace_scheduler_map_port_arbiter.sv
// Combinational owner selection for the single map ROM port; the tracer
// always owns the port while a trace window is running.
module map_port_arbiter (
  input  logic       tracing,
  input  logic       ovl_req,
  input  logic [3:0] tracer_map_col,
  input  logic [3:0] tracer_map_row,
  input  logic [3:0] ovl_map_col,
  input  logic [3:0] ovl_map_row,
  output logic       ovl_gnt,
  output logic [3:0] map_col,
  output logic [3:0] map_row
);

  assign ovl_gnt = ovl_req && !tracing;
  assign map_col = ovl_gnt ? ovl_map_col : tracer_map_col;
  assign map_row = ovl_gnt ? ovl_map_row : tracer_map_row;

endmodule

// File: rtl/trace_scheduler.sv
// Per-frame trace window sequencer with a one-stage column-buffer write path.
// Optional macro TRACE_HEIGHT_CLAMP_EN clamps written heights to 1..MAX_HEIGHT.
module trace_scheduler
  import trace_scheduler_pkg::*;
#(
  parameter int NUM_COLS = 640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  output logic        tracer_enable,
  input  logic        tracer_store,
  input  logic [9:0]  tracer_column,
  input  logic        tracer_side,
  input  logic [7:0]  tracer_height,
  input  logic [3:0]  tracer_map_col,
  input  logic [3:0]  tracer_map_row,
  input  logic        ovl_req,
  input  logic [3:0]  ovl_map_col,
  input  logic [3:0]  ovl_map_row,
  output logic        ovl_gnt,
  output logic [3:0]  map_col,
  output logic [3:0]  map_row,
  output logic        buf_we,
  output logic [9:0]  buf_addr,
  output logic [8:0]  buf_wdata,
  output logic [7:0]  frame,
  output logic        busy,
  output logic        overrun,
  output state_t      fsm_state
);

  state_t      state_q, state_d;
  logic [10:0] count_q, count_d, count_inc;
  logic [7:0]  frame_q;
  logic        overrun_q;
  logic        we_q;
  logic [9:0]  addr_q;
  buf_word_t   wdata_q;
  logic        capture, last_pixel, open_win, timeout;
  logic [7:0]  wr_height;

  // tracer_store is a valid-only pulse: there is no back-pressure, every pulse
  // seen in TRACING is consumed on that edge and appears on the write port
  // for exactly the following cycle.
  assign capture    = (state_q == ST_TRACING) && tracer_store;
  assign last_pixel = (hpos == 10'(H_TOTAL - 1)) && (vpos == 10'(V_TOTAL - 1));
  assign count_inc  = count_q + 11'(capture);

`ifdef TRACE_HEIGHT_CLAMP_EN
  assign wr_height = clamp_height(tracer_height);
`else
  assign wr_height = tracer_height;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    open_win = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hpos == '0 && vpos == 10'(VBLANK_START)) begin
          state_d  = ST_TRACING;
          open_win = 1'b1;
          count_d  = '0;
        end
      end
      ST_TRACING: begin
        count_d = count_inc;
        // End of blanking closes the window even if the final store lands here.
        if (last_pixel) begin
          state_d = ST_IDLE;
          timeout = (count_inc < 11'(NUM_COLS));
        end else if (count_inc == 11'(NUM_COLS)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (last_pixel) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      frame_q   <= '0;
      overrun_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (open_win) begin
        frame_q   <= frame_q + 8'd1;
        overrun_q <= 1'b0;
      end else if (timeout) begin
        overrun_q <= 1'b1;
      end
      // Out-of-range columns still count toward completion but never write.
      we_q <= capture && ({1'b0, tracer_column} < 11'(NUM_COLS));
      if (capture) begin
        addr_q         <= tracer_column;
        wdata_q.side   <= tracer_side;
        wdata_q.height <= wr_height;
      end
    end
  end

  assign tracer_enable = (state_q == ST_TRACING);
  assign busy          = (state_q == ST_TRACING);
  assign frame         = frame_q;
  assign overrun       = overrun_q;
  assign buf_we        = we_q;
  assign buf_addr      = addr_q;
  assign buf_wdata     = wdata_q;
  assign fsm_state     = state_q;

  map_port_arbiter u_arb (
    .tracing        (state_q == ST_TRACING),
    .ovl_req        (ovl_req),
    .tracer_map_col (tracer_map_col),
    .tracer_map_row (tracer_map_row),
    .ovl_map_col    (ovl_map_col),
    .ovl_map_row    (ovl_map_row),
    .ovl_gnt        (ovl_gnt),
    .map_col        (map_col),
    .map_row        (map_row)
  );

endmodule

// File: tb/tb_trace_scheduler.sv
// Bench for trace_scheduler: scripted window scenarios plus a randomized
// phase, all checked against a frame-level model every cycle.
module tb_trace_scheduler;
  import trace_scheduler_pkg::*;

  localparam int NCOLS = 640;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos, vpos;
  logic       tracer_enable, tracer_store, tracer_side;
  logic [9:0] tracer_column;
  logic [7:0] tracer_height;
  logic [3:0] tracer_map_col, tracer_map_row, ovl_map_col, ovl_map_row;
  logic       ovl_req, ovl_gnt;
  logic [3:0] map_col, map_row;
  logic       buf_we;
  logic [9:0] buf_addr;
  logic [8:0] buf_wdata;
  logic [7:0] frame;
  logic       busy, overrun;
  state_t     fsm_state;

  int total = 0;
  int bad   = 0;

  // expected writes: {addr[9:0], side, height[7:0]}
  logic [18:0] exp_q[$];
  int m_mode  = 0;   // 0 idle, 1 tracing, 2 done
  int m_frame = 0;
  int m_count = 0;
  bit m_ovr   = 0;
  bit checking = 0;

  trace_scheduler #(.NUM_COLS(NCOLS)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .tracer_enable(tracer_enable), .tracer_store(tracer_store),
    .tracer_column(tracer_column), .tracer_side(tracer_side),
    .tracer_height(tracer_height), .tracer_map_col(tracer_map_col),
    .tracer_map_row(tracer_map_row), .ovl_req(ovl_req),
    .ovl_map_col(ovl_map_col), .ovl_map_row(ovl_map_row),
    .ovl_gnt(ovl_gnt), .map_col(map_col), .map_row(map_row),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .frame(frame), .busy(busy), .overrun(overrun), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_height(input int h);
`ifdef TRACE_HEIGHT_CLAMP_EN
    if (h == 0) return 1;
    if (h > 240) return 240;
    return h;
`else
    return h;
`endif
  endfunction

  // frame-level reference model, advanced on each active edge
  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_frame = 0; m_count = 0; m_ovr = 0;
      exp_q.delete();
      checking = 1;
    end else begin
      case (m_mode)
        0: if (hpos == 0 && vpos == 480) begin
             m_mode = 1; m_frame = (m_frame + 1) % 256; m_count = 0; m_ovr = 0;
           end
        1: begin
             if (tracer_store) begin
               m_count++;
               if (tracer_column < NCOLS)
                 exp_q.push_back({tracer_column, tracer_side, 8'(exp_height(tracer_height))});
             end
             if (hpos == 799 && vpos == 524) begin
               m_mode = 0;
               if (m_count < NCOLS) m_ovr = 1;
             end else if (m_count == NCOLS) begin
               m_mode = 2;
             end
           end
        default: if (hpos == 799 && vpos == 524) m_mode = 0;
      endcase
    end
  end

  // compare process: every cycle, on the inactive edge
  always @(negedge clk) begin
    if (checking) begin
      logic [18:0] e;
      bit gnt;
      gnt = ovl_req && (m_mode != 1);
      chk("state", int'(fsm_state), m_mode);
      chk("tracer_enable", tracer_enable, m_mode == 1);
      chk("busy", busy, m_mode == 1);
      chk("frame", frame, m_frame);
      chk("overrun", overrun, m_ovr);
      chk("ovl_gnt", ovl_gnt, gnt);
      chk("map_col", map_col, gnt ? ovl_map_col : tracer_map_col);
      chk("map_row", map_row, gnt ? ovl_map_row : tracer_map_row);
      if (buf_we) begin
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("buf_addr", buf_addr, e[18:9]);
          chk("buf_wdata", buf_wdata, e[8:0]);
        end
      end else begin
        chk("missing_write", exp_q.size(), 0);
      end
    end
  end

  // driver tasks
  task automatic cycle(input int h, input int v, input bit st, input bit rst,
                       input int col, input bit side, input int height);
    hpos = 10'(h); vpos = 10'(v); reset = rst;
    tracer_store = st; tracer_column = 10'(col);
    tracer_side = side; tracer_height = 8'(height);
    tracer_map_col = 4'($urandom_range(0, 15));
    tracer_map_row = 4'($urandom_range(0, 15));
    ovl_map_col = 4'($urandom_range(0, 15));
    ovl_map_row = 4'($urandom_range(0, 15));
    ovl_req = ($urandom_range(0, 3) != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v, input bit st, input bit rst);
    int ht;
    case ($urandom_range(0, 3))
      0: ht = 0;
      1: ht = 250;
      default: ht = $urandom_range(0, 255);
    endcase
    cycle(h, v, st, rst, $urandom_range(0, 703), 1'($urandom_range(0, 1)), ht);
  endtask

  // in-blanking position that is neither the open pixel nor the last pixel
  task automatic mid(input bit st);
    drive($urandom_range(1, 798), $urandom_range(481, 523), st, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive($urandom_range(0, 799), $urandom_range(0, 479), $urandom_range(0, 1), 0);
  endtask

  initial begin
    int n;
    bit st;
    int r;
    drive(3, 3, 0, 1);
    drive(3, 3, 1, 1);
    chk("rst_enable", tracer_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", buf_we, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_addr", buf_addr, 0);
    chk("rst_wdata", buf_wdata, 0);
    chk("rst_frame", frame, 0);
    idle(5);

    // window that completes
    drive(0, 480, 1, 0);
    chk("open_enable", tracer_enable, 1);
    chk("open_frame", frame, 1);
    chk("open_busy", busy, 1);
    for (int c = 0; c < 4; c++) begin
      cycle(100 + c, 481, 1, 0, c, 0, 10 * (c + 1));
      chk("lit_we", buf_we, 1);
      chk("lit_addr", buf_addr, c);
      chk("lit_wdata", buf_wdata, 10 * (c + 1));
    end
    cycle(200, 482, 1, 0, 4, 0, 0);
`ifdef TRACE_HEIGHT_CLAMP_EN
    chk("lit_h0", buf_wdata, 1);
`else
    chk("lit_h0", buf_wdata, 0);
`endif
    cycle(201, 482, 1, 0, 5, 1, 250);
`ifdef TRACE_HEIGHT_CLAMP_EN
    chk("lit_h250", buf_wdata, 256 + 240);
`else
    chk("lit_h250", buf_wdata, 256 + 250);
`endif
    n = 6;
    while (n < NCOLS) begin
      st = 1'($urandom_range(0, 1));
      mid(st);
      if (st) n++;
    end
    chk("done_enable", tracer_enable, 0);
    chk("done_busy", busy, 0);
    for (int i = 0; i < 6; i++) mid(1);
    drive(799, 524, 1, 0);
    chk("done_overrun", overrun, 0);
    idle(4);

    // window that times out with 240 stores
    drive(0, 480, 0, 0);
    chk("open2_frame", frame, 2);
    n = 0;
    while (n < 240) begin
      st = 1'($urandom_range(0, 1));
      mid(st);
      if (st) n++;
    end
    for (int i = 0; i < 5; i++) mid(0);
    drive(799, 524, 0, 0);
    chk("timeout_overrun", overrun, 1);
    chk("timeout_enable", tracer_enable, 0);
    idle(6);
    chk("overrun_sticky", overrun, 1);
    drive(0, 480, 0, 0);
    chk("overrun_clear", overrun, 0);
    chk("open3_frame", frame, 3);

    // reset in the middle of a window drops the store it coincides with
    mid(1);
    mid(0);
    drive(300, 490, 1, 1);
    chk("midrst_we", buf_we, 0);
    chk("midrst_frame", frame, 0);
    chk("midrst_enable", tracer_enable, 0);
    mid(1);
    chk("midrst_no_write", buf_we, 0);
    idle(5);
    chk("midrst_frame_hold", frame, 0);

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      st = 1'($urandom_range(0, 1));
      if (r < 3) drive(0, 480, st, 0);
      else if (r < 6) drive(799, 524, st, 0);
      else if (r == 6) drive($urandom_range(0, 799), $urandom_range(0, 524), st, 1);
      else if (r < 60) mid(st);
      else drive($urandom_range(0, 799), $urandom_range(0, 524), st, 0);
    end
    idle(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
